// File: rtl/ahb_dp_mux_pkg.sv
// ahb_dp_mux_pkg: shared defaults and channel bound for the AHB data-phase mux.
package ahb_dp_mux_pkg;
  localparam int REQ_W_DEF = 78;
  localparam int RSP_W_DEF = 34;
  localparam int CH_MAX    = 16;
endpackage

// File: rtl/ahb_dp_mux_prio.sv
// ahb_dp_mux_prio: lowest-index priority one-hot encoder with multi-hit flag.
module ahb_dp_mux_prio #(
  parameter int N = 2
) (
  input  logic [N-1:0] in,
  output logic [N-1:0] oh,
  output logic         multi
);
  always_comb begin
    oh = '0;
    for (int i = N - 1; i >= 0; i--)
      if (in[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
  end
  assign multi = |(in & ~oh);
endmodule

// File: rtl/ahb_dp_mux.sv
// ahb_dp_mux: AHB address/data-phase channel mux; AHB_DP_MUX_ONEHOT_CHK_EN enables the sticky multi-select flag.
module ahb_dp_mux
  import ahb_dp_mux_pkg::*;
#(
  parameter int CHANNEL_NUM = 2,
  parameter int REQ_W       = REQ_W_DEF,
  parameter int RSP_W       = RSP_W_DEF
) (
  input  logic                              HCLK,
  input  logic                              HRESETn,
  input  logic [CHANNEL_NUM-1:0][REQ_W-1:0] req_in,
  input  logic [CHANNEL_NUM-1:0]            sel_a,
  output logic [REQ_W-1:0]                  req_out,
  input  logic [CHANNEL_NUM-1:0][RSP_W-1:0] rsp_in,
  input  logic [CHANNEL_NUM-1:0]            rdy_in,
  output logic [RSP_W-1:0]                  rsp_out,
  output logic                              hready_out,
  output logic [CHANNEL_NUM-1:0]            dsel_out,
  output logic                              sel_err
);
  logic [CHANNEL_NUM-1:0] sel_eff, dsel;
`ifdef AHB_DP_MUX_ONEHOT_CHK_EN
  logic multi;
`else
  logic unused_multi;
`endif
  ahb_dp_mux_prio #(.N(CHANNEL_NUM)) u_prio (
    .in   (sel_a),
    .oh   (sel_eff),
`ifdef AHB_DP_MUX_ONEHOT_CHK_EN
    .multi(multi)
`else
    .multi(unused_multi)
`endif
  );
  // Selects are one-hot after encoding/registering, so masked OR is a clean mux.
  always_comb begin
    req_out = '0;
    rsp_out = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      req_out = req_out | ({REQ_W{sel_eff[i]}} & req_in[i]);
      rsp_out = rsp_out | ({RSP_W{dsel[i]}} & rsp_in[i]);
    end
  end
  assign hready_out = ~|dsel | |(dsel & rdy_in);
  assign dsel_out   = dsel;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) dsel <= '0;
    else if (hready_out) dsel <= sel_eff;
`ifdef AHB_DP_MUX_ONEHOT_CHK_EN
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) sel_err <= 1'b0;
    else if (hready_out && multi) sel_err <= 1'b1;
`else
  assign sel_err = 1'b0;
`endif
endmodule
